// File: rtl/tmds_pkg.sv
// Shared TMDS serializer constants.
//   - The four TMDS control symbols (c = 00/01/10/11) and the default idle symbol.
//   - PRBS7 (x^7 + x^6 + 1) width, feedback taps and per-lane seed helper,
//     used only when TMDS_PRBS_EN is defined.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_C00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_C01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_C10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_C11 = 10'b1010101011;

    localparam logic [9:0] TMDS_IDLE_SYM = TMDS_CTRL_C00;

    localparam int PRBS7_W      = 7;
    localparam int PRBS7_TAP_HI = 6;    // x^7 term
    localparam int PRBS7_TAP_LO = 5;    // x^6 term

    // Lane ch starts from a distinct non-zero state so lanes are decorrelated.
    function automatic logic [PRBS7_W-1:0] prbs7_seed(input int ch);
        return PRBS7_W'(ch + 1);
    endfunction

endpackage

// File: rtl/tmds_prbs7_step.sv
// Combinational PRBS7 (x^7 + x^6 + 1) generator for one lane.
// Advances the LFSR SYM_W steps and returns the generated bits LSB first
// (bit 0 is the first bit produced) together with the resulting state.
// Ports:
//   state_in   in   PRBS7_W  current LFSR state
//   sym_bits   out  SYM_W    next SYM_W PRBS bits, LSB first in time
//   state_out  out  PRBS7_W  LFSR state after SYM_W steps
module tmds_prbs7_step
    import tmds_pkg::*;
#(
    parameter int SYM_W = 10
) (
    input  logic [PRBS7_W-1:0] state_in,
    output logic [SYM_W-1:0]   sym_bits,
    output logic [PRBS7_W-1:0] state_out
);

    logic [PRBS7_W-1:0] s;
    logic               fb;

    always_comb begin
        s        = state_in;
        sym_bits = '0;
        fb       = 1'b0;
        for (int i = 0; i < SYM_W; i++) begin
            fb          = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
            sym_bits[i] = fb;
            s           = {s[PRBS7_W-2:0], fb};
        end
        state_out = s;
    end

endmodule

// File: rtl/tmds_lane_serializer.sv
// Parametrised single-clock TMDS lane serializer.
// Accepts SYM_W-bit symbols for NUM_CH lanes over valid/ready, buffers one
// group in a skid/hold register and shifts OUT_BITS bits per lane per clk out
// to the I/O cells, plus a generated pixel-clock lane. Inserts IDLE_SYM when
// no symbol is available at a load and flags the underrun (sticky).
// Optional build macro: TMDS_PRBS_EN adds prbs_en, which replaces every loaded
// symbol with a per-lane PRBS7 pattern.
// Ports:
//   clk           in   1                serial-slice clock
//   reset         in   1                synchronous, active-high
//   prbs_en       in   1                (TMDS_PRBS_EN only) PRBS7 test pattern select
//   sym_data      in   NUM_CH*SYM_W     lane ch symbol at [ch*SYM_W +: SYM_W]
//   sym_valid     in   1                symbol group valid
//   sym_ready     out  1                group accepted this cycle if valid
//   underrun_clr  in   1                clears underrun
//   lane_out      out  NUM_CH*OUT_BITS  lane ch slice, bit 0 first in time
//   clk_out       out  OUT_BITS         clock-lane slice, bit 0 first in time
//   sym_start     out  1                first slice of a symbol on outputs
//   underrun      out  1                sticky idle-insertion flag
module tmds_lane_serializer
    import tmds_pkg::*;
#(
    parameter int               NUM_CH   = 3,
    parameter int               SYM_W    = 10,
    parameter int               OUT_BITS = 2,
    parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(TMDS_IDLE_SYM)
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef TMDS_PRBS_EN
    input  logic                       prbs_en,
`endif
    input  logic [NUM_CH*SYM_W-1:0]    sym_data,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic                       underrun_clr,
    output logic [NUM_CH*OUT_BITS-1:0] lane_out,
    output logic [OUT_BITS-1:0]        clk_out,
    output logic                       sym_start,
    output logic                       underrun
);

    localparam int PH   = SYM_W / OUT_BITS;
    localparam int PH_W = (PH > 1) ? $clog2(PH) : 1;

    if (SYM_W % OUT_BITS != 0) begin : g_bad_ratio
        $error("tmds_lane_serializer: SYM_W must be a multiple of OUT_BITS");
    end

    logic [PH_W-1:0]         phase_q, phase_d;
    logic [NUM_CH*SYM_W-1:0] shift_q, shift_d;
    logic [NUM_CH*SYM_W-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    armed_q, armed_d;
    logic                    underrun_q, underrun_d;

    logic load;
    logic accept;
    logic prbs_active;

    assign load      = (phase_q == PH_W'(PH - 1));
    assign sym_ready = !hold_full_q || load;
    assign accept    = sym_valid && sym_ready;
    assign sym_start = (phase_q == '0);
    assign underrun  = underrun_q;

`ifdef TMDS_PRBS_EN
    logic [NUM_CH*PRBS7_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [NUM_CH*SYM_W-1:0]   prbs_sym;

    assign prbs_active = prbs_en;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_prbs
        tmds_prbs7_step #(.SYM_W(SYM_W)) u_step (
            .state_in  (lfsr_q[ch*PRBS7_W +: PRBS7_W]),
            .sym_bits  (prbs_sym[ch*SYM_W +: SYM_W]),
            .state_out (lfsr_step[ch*PRBS7_W +: PRBS7_W])
        );
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (load && prbs_active) lfsr_d = lfsr_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                lfsr_q[ch*PRBS7_W +: PRBS7_W] <= prbs7_seed(ch);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign prbs_active = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane_out
        assign lane_out[ch*OUT_BITS +: OUT_BITS] = shift_q[ch*SYM_W +: OUT_BITS];
    end

    // Clock lane: high for the first half of each symbol period.
    always_comb begin
        clk_out = '0;
        for (int k = 0; k < OUT_BITS; k++)
            clk_out[k] = ((int'(phase_q) * OUT_BITS + k) < (SYM_W / 2));
    end

    always_comb begin
        phase_d     = phase_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        armed_d     = armed_q | accept;
        underrun_d  = underrun_q;

        // Clear first so a same-cycle set below takes priority.
        if (underrun_clr) underrun_d = 1'b0;

        if (load) begin
            phase_d = '0;
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = accept;
                if (accept) hold_d = sym_data;
            end else if (accept) begin
                shift_d = sym_data;
            end else begin
                shift_d = {NUM_CH{IDLE_SYM}};
                if (armed_q && !prbs_active) underrun_d = 1'b1;
            end
`ifdef TMDS_PRBS_EN
            if (prbs_active) shift_d = prbs_sym;
`endif
        end else begin
            phase_d = phase_q + 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++)
                shift_d[ch*SYM_W +: SYM_W] = shift_q[ch*SYM_W +: SYM_W] >> OUT_BITS;
            if (accept) begin
                hold_d      = sym_data;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            shift_q     <= {NUM_CH{IDLE_SYM}};
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule
